sdc_spi_slave: RTL and testbench
================================

Name: sdc_spi_slave

Overview:
- SPI target (slave) for the SD-card SPI link; the receiving end of the controller-side SPI master.
- Used in the bench/SD-card emulator FPGA and as a loopback peer for controller bring-up.
- Oversamples sclk/mosi/cs_n in its own clock domain, in SPI mode 0 (sample on sclk rise, shift on sclk fall).
- Frames are 8 or 32 bits with the master's bit order; provides a word-level rx/tx handshake to local logic.

Parameters:
SYNC_STAGES, 2, synchronizer depth on sclk/mosi/cs_n (legal 2..3)
IDLE_FILL, 32'hFFFFFFFF, word shifted out when no tx word is pending (SD idle-high)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
fast  in  1  1 = 32-bit frame, 0 = 8-bit frame; sampled at frame start
tx_data  in  32  word for the next frame
tx_wr  in  1  load tx_data into holding register (one-cycle pulse)
tx_empty  out  1  holding register free
rx_data  out  32  last completed frame; 8-bit frames zero-extended
rx_valid  out  1  one-cycle pulse: rx_data updated
busy  out  1  frame in progress (cs_n low, bit count nonzero)
cs_n  in  1  chip select from master, active-low, asynchronous
sclk  in  1  SPI clock from master, asynchronous, idles low
mosi  in  1  data from master, asynchronous
miso  out  1  data to master
miso_oe  out  1  miso pad enable = synchronized ~cs_n

Behaviour:
- Reset values: tx_empty=1, rx_data=0, rx_valid=0, busy=0, miso=1, miso_oe=0, bit counter=0, shift register=IDLE_FILL.
- Sync and edges: sclk, mosi and cs_n each pass through SYNC_STAGES flops. Rise/fall is detected from the last two sclk stages. Equal mosi/sclk depth keeps their relative timing.
- Timing requirement: sclk high and low phases each >= 2 clk periods. miso changes <= SYNC_STAGES+1 clk after the sclk pin falls.
- Bit order (identical to master):
  - 32-bit frame: bits 7..0, then 15..8, 23..16, 31..24 (bytes LS first, MSB first within byte).
  - 8-bit frame: bits 7..0.
- Frame start: cs_n falling, or the sclk fall after a frame's final rise while cs_n stays low. At start:
  - latch fast;
  - load shift register from holding register if full (set tx_empty=1), else from IDLE_FILL;
  - drive first bit on miso.
- sclk rise (cs_n low): shift synchronized mosi into receive chain; increment bit counter.
- Frame end: on the 8th/32nd rise, next clk:
  - rx_data <= assembled word (8-bit frame: {24'b0, byte});
  - rx_valid=1 for one cycle;
  - bit counter <= 0.
- sclk fall within a frame: advance transmit chain; miso = next bit.
- cs_n high (synchronized):
  - abort any partial frame, bit counter=0, no rx_valid, partial rx discarded;
  - holding register kept;
  - miso=1, miso_oe=0;
  - sclk edges ignored.
- tx_wr while tx_empty=0: overwrites holding word. tx_wr coinciding with a frame-start load: the load takes the old word and tx_wr fills the now-free register (tx_empty stays 0).
- rx_data is not held off; an unread word is overwritten by the next frame.
- Asynchronous rst mid-frame returns everything to reset values immediately.

Optional Feature:
SDC_SPI_SLV_ERR_EN
- Defined: adds err_clr input (1) and err output [1:0], both sticky until err_clr pulse.
  - err[0] underrun: frame started with tx_empty=1.
  - err[1] abort: cs_n rose with bit counter nonzero.
  - err_clr wins over a simultaneous set.
- Undefined: ports absent, no flag logic.

Decomposition:
- Package sdc_spi_pkg: frame-length constants (BITS8=8, BITS32=32), IDLE_FILL default, err bit indices.
- Sub-module sdc_sync: SYNC_STAGES-deep 1-bit synchronizer with async reset value, instantiated 3x (sclk reset 0, mosi 1, cs_n 1).

Test Plan:
1. fast=0, tx_wr 32'h000000A5, master sends 8'h3C (sclk period 256 clk) -> miso bits 1,0,1,0,0,1,0,1; rx_data=32'h0000003C; one rx_valid; tx_empty=1 after frame start.
2. fast=1, tx word 32'h11223344, master sends 32'hDEADBEEF (sclk high 2/low 2 at slave clk) -> miso byte order 44,33,22,11; rx_data=32'hDEADBEEF.
3. No tx_wr, 8-bit frame -> miso all 1s (0xFF); with SDC_SPI_SLV_ERR_EN, err[0]=1 until err_clr.
4. Two back-to-back 8-bit frames, cs_n held low, second tx_wr during first frame -> two rx_valid pulses; second frame shifts the second word.
5. cs_n raised after 5 bits -> no rx_valid, busy=0, miso=1, miso_oe=0; next full frame received correctly; err[1]=1 if enabled.
6. rst asserted mid 32-bit frame -> all outputs at reset values same cycle; post-reset frame correct.

Source files
------------

// File: rtl/sdc_spi_pkg.sv
// Shared constants, FSM states and byte-order helper for the SD-card SPI slave.
// Pure declarations: no latency, no backpressure.
package sdc_spi_pkg;

   localparam int          BITS8         = 8;
   localparam int          BITS32        = 32;
   localparam logic [31:0] IDLE_FILL_DEF = 32'hFFFF_FFFF;
   localparam int          ERR_UNDERRUN  = 0;
   localparam int          ERR_ABORT     = 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_WAIT
   } state_e;

   // Wire order is bytes LS first, MSB first within a byte; swapping bytes
   // lets a plain MSB-first shifter produce and consume that order.
   function automatic logic [31:0] bswap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/sdc_spi_slave_if.sv
// Local word handshake plus SPI pins of the SD-card SPI slave; SDC_SPI_SLV_ERR_EN adds err flags.
// Wiring only: no latency, no backpressure (rx words are never held off).
interface sdc_spi_slave_if;

   logic        fast;
   logic [31:0] tx_data;
   logic        tx_wr;
   logic        tx_empty;
   logic [31:0] rx_data;
   logic        rx_valid;
   logic        busy;
   logic        cs_n;
   logic        sclk;
   logic        mosi;
   logic        miso;
   logic        miso_oe;
`ifdef SDC_SPI_SLV_ERR_EN
   logic        err_clr;
   logic [1:0]  err;

   modport slave (
      input  fast, tx_data, tx_wr, cs_n, sclk, mosi, err_clr,
      output tx_empty, rx_data, rx_valid, busy, miso, miso_oe, err
   );
   modport master (
      output fast, tx_data, tx_wr, cs_n, sclk, mosi, err_clr,
      input  tx_empty, rx_data, rx_valid, busy, miso, miso_oe, err
   );
`else
   modport slave (
      input  fast, tx_data, tx_wr, cs_n, sclk, mosi,
      output tx_empty, rx_data, rx_valid, busy, miso, miso_oe
   );
   modport master (
      output fast, tx_data, tx_wr, cs_n, sclk, mosi,
      input  tx_empty, rx_data, rx_valid, busy, miso, miso_oe
   );
`endif

endinterface

// File: rtl/sdc_sync.sv
// STAGES-deep single-bit synchronizer with a selectable reset value.
// Latency STAGES clk; no backpressure.
module sdc_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] ff_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ff_q <= {STAGES{RST_VAL}};
      else     ff_q <= {ff_q[STAGES-2:0], d_i};
   end

   assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/sdc_spi_slave.sv
// SPI mode-0 slave, oversampled in clk; 8/32-bit frames; optional SDC_SPI_SLV_ERR_EN sticky err flags.
// rx_valid one clk after the synchronized last rise; miso <= SYNC_STAGES+1 clk after sclk falls; no rx backpressure.
module sdc_spi_slave
   import sdc_spi_pkg::*;
#(
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] IDLE_FILL   = IDLE_FILL_DEF
) (
   input logic            clk,
   input logic            rst,
   sdc_spi_slave_if.slave bus
);

   logic sclk_s, mosi_s, cs_n_s, sclk_prev_q;

   sdc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d_i(bus.sclk), .q_o(sclk_s));
   sdc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_mosi (.clk(clk), .rst(rst), .d_i(bus.mosi), .q_o(mosi_s));
   sdc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (.clk(clk), .rst(rst), .d_i(bus.cs_n), .q_o(cs_n_s));

   state_e      state_q, state_d;
   logic [5:0]  bitcnt_q, bitcnt_d;
   logic        fast_q, fast_d;
   logic [31:0] hold_q, hold_d;
   logic        empty_q, empty_d;
   logic [31:0] tx_sh_q, tx_sh_d;
   logic [30:0] rx_sh_q, rx_sh_d;
   logic [31:0] rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d;
   logic        miso_q, miso_d;

   logic        rise, fall, start;
   logic [31:0] rx_next, ld_sw;
   logic [5:0]  last_bit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_prev_q <= 1'b0;
         state_q     <= ST_IDLE;
         bitcnt_q    <= '0;
         fast_q      <= 1'b0;
         hold_q      <= '0;
         empty_q     <= 1'b1;
         tx_sh_q     <= IDLE_FILL;
         rx_sh_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         miso_q      <= 1'b1;
      end else begin
         sclk_prev_q <= sclk_s;
         state_q     <= state_d;
         bitcnt_q    <= bitcnt_d;
         fast_q      <= fast_d;
         hold_q      <= hold_d;
         empty_q     <= empty_d;
         tx_sh_q     <= tx_sh_d;
         rx_sh_q     <= rx_sh_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         miso_q      <= miso_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bitcnt_d   = bitcnt_q;
      fast_d     = fast_q;
      hold_d     = hold_q;
      empty_d    = empty_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      miso_d     = miso_q;
      start      = 1'b0;
      rise       = sclk_s & ~sclk_prev_q;
      fall       = ~sclk_s & sclk_prev_q;
      rx_next    = {rx_sh_q, mosi_s};
      last_bit   = fast_q ? 6'(BITS32 - 1) : 6'(BITS8 - 1);
      ld_sw      = bswap(empty_q ? IDLE_FILL : hold_q);

      if (cs_n_s) begin
         state_d  = ST_IDLE;
         bitcnt_d = '0;
         miso_d   = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE:  start = 1'b1;
            ST_SHIFT: begin
               if (rise) begin
                  rx_sh_d = rx_next[30:0];
                  if (bitcnt_q == last_bit) begin
                     bitcnt_d   = '0;
                     rx_data_d  = fast_q ? bswap(rx_next) : {24'b0, rx_next[7:0]};
                     rx_valid_d = 1'b1;
                     state_d    = ST_WAIT;
                  end else begin
                     bitcnt_d = bitcnt_q + 6'd1;
                  end
               end else if (fall) begin
                  miso_d  = tx_sh_q[31];
                  tx_sh_d = {tx_sh_q[30:0], 1'b1};
               end
            end
            // The fall following the last rise opens the next frame.
            ST_WAIT:  start = fall;
            default:  state_d = ST_IDLE;
         endcase
      end

      if (start) begin
         state_d  = ST_SHIFT;
         bitcnt_d = '0;
         fast_d   = bus.fast;
         empty_d  = 1'b1;
         miso_d   = ld_sw[31];
         tx_sh_d  = {ld_sw[30:0], 1'b1};
      end

      // Applied after the frame-start load so the load takes the old word.
      if (bus.tx_wr) begin
         hold_d  = bus.tx_data;
         empty_d = 1'b0;
      end
   end

`ifdef SDC_SPI_SLV_ERR_EN
   logic [1:0] err_q, err_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= '0;
      else     err_q <= err_d;
   end

   always_comb begin
      err_d = err_q;
      if (start && empty_q)
         err_d[ERR_UNDERRUN] = 1'b1;
      if (cs_n_s && (state_q != ST_IDLE) && (bitcnt_q != 6'd0))
         err_d[ERR_ABORT] = 1'b1;
      if (bus.err_clr)
         err_d = '0;
   end

   assign bus.err = err_q;
`endif

   assign bus.tx_empty = empty_q;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.busy     = ~cs_n_s & (bitcnt_q != 6'd0);
   assign bus.miso     = cs_n_s | miso_q;
   assign bus.miso_oe  = ~cs_n_s;

endmodule

// File: tb/tb_sdc_spi_slave.sv
// Directed bench for sdc_spi_slave: a bench-side SPI master drives frames,
// expected rx words go to a scoreboard queue checked by an rx_valid monitor.
module tb_sdc_spi_slave;
   import sdc_spi_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sdc_spi_slave_if bus();

   sdc_spi_slave #(.SYNC_STAGES(2), .IDLE_FILL(32'hFFFF_FFFF)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] rx_exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic tx_write(input logic [31:0] d);
      @(posedge clk); #1;
      bus.tx_data = d;
      bus.tx_wr   = 1'b1;
      @(posedge clk); #1;
      bus.tx_wr   = 1'b0;
   endtask

   // Bit k of the frame carries word bit 8*(k/8)+7-(k%8); miso is sampled 2 clk after each rise.
   task automatic spi_xfer(input logic [31:0] w, input int half, input int nbits, output logic [31:0] obs);
      obs = '0;
      for (int k = 0; k < nbits; k++) begin
         int idx;
         idx = 8 * (k / 8) + 7 - (k % 8);
         bus.mosi = w[idx];
         repeat (half) @(posedge clk);
         #1 bus.sclk = 1'b1;
         repeat (2) @(posedge clk);
         #1 obs[idx] = bus.miso;
         repeat (half - 2) @(posedge clk);
         #1 bus.sclk = 1'b0;
      end
   endtask

   task automatic do_frame(input string nm, input logic [31:0] mw, input bit is32, input int half,
                           input logic [31:0] exp_miso);
      logic [31:0] obs;
      bus.fast = is32;
      rx_exp_q.push_back(is32 ? mw : {24'b0, mw[7:0]});
      bus.cs_n = 1'b0;
      repeat (6) @(posedge clk); #1;
      spi_xfer(mw, half, is32 ? 32 : 8, obs);
      chk(nm, obs, exp_miso);
      repeat (half) @(posedge clk);
      #1 bus.cs_n = 1'b1;
      repeat (6) @(posedge clk); #1;
   endtask

`ifdef SDC_SPI_SLV_ERR_EN
   task automatic err_clear();
      @(posedge clk); #1 bus.err_clr = 1'b1;
      @(posedge clk); #1 bus.err_clr = 1'b0;
   endtask
`endif

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_tx_empty"}, 32'(bus.tx_empty), 32'd1);
      chk({tag, "_rx_data"},  bus.rx_data,       32'd0);
      chk({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
      chk({tag, "_busy"},     32'(bus.busy),     32'd0);
      chk({tag, "_miso"},     32'(bus.miso),     32'd1);
      chk({tag, "_miso_oe"},  32'(bus.miso_oe),  32'd0);
   endtask

   // Scoreboard monitor: every rx_valid pulse must match the oldest expected word.
   initial begin
      logic [31:0] e;
      forever begin
         @(posedge clk); #1;
         if (bus.rx_valid === 1'b1) begin
            if (rx_exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rx_unexpected: got rx_valid with rx_data %h, required no rx_valid", bus.rx_data);
            end else begin
               e = rx_exp_q.pop_front();
               chk("rx_data", bus.rx_data, e);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] o1, o2;
      rst         = 1'b1;
      bus.cs_n    = 1'b1;
      bus.sclk    = 1'b0;
      bus.mosi    = 1'b1;
      bus.fast    = 1'b0;
      bus.tx_wr   = 1'b0;
      bus.tx_data = '0;
`ifdef SDC_SPI_SLV_ERR_EN
      bus.err_clr = 1'b0;
`endif
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk_reset_vals("rst");

      // 1: slow 8-bit frame
      tx_write(32'h0000_00A5);
      chk("t1_tx_empty_loaded", 32'(bus.tx_empty), 32'd0);
      bus.fast = 1'b0;
      rx_exp_q.push_back(32'h0000_003C);
      bus.cs_n = 1'b0;
      repeat (6) @(posedge clk); #1;
      chk("t1_tx_empty_started", 32'(bus.tx_empty), 32'd1);
      chk("t1_miso_oe", 32'(bus.miso_oe), 32'd1);
      spi_xfer(32'h0000_003C, 128, 8, o1);
      chk("t1_miso", o1, 32'h0000_00A5);
      repeat (128) @(posedge clk);
      #1 bus.cs_n = 1'b1;
      repeat (6) @(posedge clk); #1;

      // 2: fast 32-bit frame, 2/2 clk sclk phases
      tx_write(32'h1122_3344);
      do_frame("t2_miso", 32'hDEAD_BEEF, 1'b1, 2, 32'h1122_3344);

      // 3: underrun shifts the idle fill
`ifdef SDC_SPI_SLV_ERR_EN
      err_clear();
`endif
      do_frame("t3_miso", 32'h0000_005A, 1'b0, 4, 32'h0000_00FF);
`ifdef SDC_SPI_SLV_ERR_EN
      chk("t3_err_underrun", 32'(bus.err[ERR_UNDERRUN]), 32'd1);
      err_clear();
      chk("t3_err_cleared", 32'(bus.err), 32'd0);
`endif

      // 4: back-to-back frames, second word written mid first frame
      tx_write(32'h0000_0012);
      bus.fast = 1'b0;
      rx_exp_q.push_back(32'h0000_0081);
      rx_exp_q.push_back(32'h0000_007E);
      bus.cs_n = 1'b0;
      repeat (6) @(posedge clk); #1;
      fork
         spi_xfer(32'h0000_0081, 4, 8, o1);
         begin
            repeat (12) @(posedge clk);
            tx_write(32'h0000_0034);
         end
      join
      chk("t4_miso_first", o1, 32'h0000_0012);
      spi_xfer(32'h0000_007E, 4, 8, o2);
      chk("t4_miso_second", o2, 32'h0000_0034);
      repeat (4) @(posedge clk);
      #1 bus.cs_n = 1'b1;
      repeat (6) @(posedge clk); #1;

      // 5: abort after 5 bits, then a clean frame
`ifdef SDC_SPI_SLV_ERR_EN
      err_clear();
`endif
      bus.fast = 1'b0;
      bus.cs_n = 1'b0;
      repeat (6) @(posedge clk); #1;
      spi_xfer(32'h0000_00F0, 4, 5, o1);
      repeat (2) @(posedge clk); #1;
      chk("t5_busy_mid", 32'(bus.busy), 32'd1);
      bus.cs_n = 1'b1;
      repeat (4) @(posedge clk); #1;
      chk("t5_busy_abort", 32'(bus.busy), 32'd0);
      chk("t5_miso_abort", 32'(bus.miso), 32'd1);
      chk("t5_oe_abort", 32'(bus.miso_oe), 32'd0);
`ifdef SDC_SPI_SLV_ERR_EN
      chk("t5_err_abort", 32'(bus.err[ERR_ABORT]), 32'd1);
`endif
      tx_write(32'h0000_005C);
      do_frame("t5_miso", 32'h0000_00C3, 1'b0, 4, 32'h0000_005C);

      // 6: reset in the middle of a 32-bit frame
      bus.fast = 1'b1;
      bus.cs_n = 1'b0;
      repeat (6) @(posedge clk); #1;
      spi_xfer(32'h1357_9BDF, 2, 12, o1);
      tx_write(32'h0000_0077);
      chk("t6_tx_empty_pre", 32'(bus.tx_empty), 32'd0);
      chk("t6_busy_pre", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      #1;
      chk_reset_vals("t6_rst");
      bus.cs_n = 1'b1;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) @(posedge clk); #1;
      tx_write(32'hAABB_CCDD);
      do_frame("t6_miso", 32'h0123_4567, 1'b1, 2, 32'hAABB_CCDD);

      repeat (20) @(posedge clk); #1;
      chk("rx_pending", 32'(rx_exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
